// File: rtl/ula_fl_arb_pkg.sv
// Shared types and constants for the ula_fl round-robin arbiter.
// Opcodes mirror the ula_fl encoding and are forwarded without decoding.
package ula_fl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MLT  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_EQ   = 4'd6;
  localparam logic [3:0] OP_NE   = 4'd7;
  localparam logic [3:0] OP_LT   = 4'd8;
  localparam logic [3:0] OP_GT   = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_OR   = 4'd11;
  localparam logic [3:0] OP_ABS  = 4'd12;
  localparam logic [3:0] OP_SIGN = 4'd13;

  function automatic int word_w(input int exp_w, input int man_w);
    return man_w + exp_w + 1;
  endfunction

endpackage

// File: rtl/ula_fl_arb_rr_pick.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... mod N.
// Zero latency; found_o is low and outputs are zero when no request is set.
module rr_pick #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = IDW'((int'(ptr_i) + off) % N);
      if (!found_o && req_i[cand]) begin
        found_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ula_fl_arb.sv
// Shares one combinational ula_fl among NREQ requesters; operands held LAT cycles, result
// returned LAT edges after grant. No new grant until the response is acked (rsp_ack stalls).
module ula_fl_arb
  import ula_fl_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int LAT  = 2,
  localparam int W   = word_w(EXP, MAN),
  localparam int IDW = $clog2(NREQ),
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_in1,
  input  logic [W*NREQ-1:0]   req_in2,
  output logic [NREQ-1:0]     gnt,
  output logic                rsp_vld,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_out,
  input  logic                rsp_ack,
  output logic [3:0]          alu_op,
  output logic [W-1:0]        alu_in1,
  output logic [W-1:0]        alu_in2,
  input  logic [W-1:0]        alu_out
);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      alu_op_q;
  logic [W-1:0]    alu_in1_q;
  logic [W-1:0]    alu_in2_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_out_q;
  logic            rsp_vld_q;

  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_found;

  logic [3:0]      op_arr  [NREQ];
  logic [W-1:0]    in1_arr [NREQ];
  logic [W-1:0]    in2_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]  = req_op[4*g +: 4];
    assign in1_arr[g] = req_in1[W*g +: W];
    assign in2_arr[g] = req_in2[W*g +: W];
  end

  rr_pick #(.N(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  // Grant is combinational so the requester sees it on the same edge the operands are latched.
  assign gnt = (state_q == ST_IDLE && !rst) ? pick_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      rsp_id_q  <= '0;
      rsp_out_q <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            alu_op_q  <= op_arr[pick_idx];
            alu_in1_q <= in1_arr[pick_idx];
            alu_in2_q <= in2_arr[pick_idx];
            rsp_id_q  <= pick_idx;
            cnt_q     <= CW'(LAT - 1);
            ptr_q     <= ptr_d;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            rsp_out_q <= alu_out;
            rsp_vld_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ack) begin
            rsp_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_in1 = alu_in1_q;
  assign alu_in2 = alu_in2_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_out = rsp_out_q;
  assign rsp_vld = rsp_vld_q;

endmodule

// File: tb/tb_ula_fl_arb.sv
// Self-checking bench for ula_fl_arb: directed table, multi-cycle corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_ula_fl_arb;
  import ula_fl_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int EXP  = 8;
  localparam int MAN  = 23;
  localparam int LAT  = 2;
  localparam int W    = MAN + EXP + 1;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [4*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_in1;
  logic [W*NREQ-1:0]   req_in2;
  logic [NREQ-1:0]     gnt;
  logic                rsp_vld;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_out;
  logic                rsp_ack;
  logic [3:0]          alu_op;
  logic [W-1:0]        alu_in1;
  logic [W-1:0]        alu_in2;
  logic [W-1:0]        alu_out;

  logic [3:0]   op_a  [NREQ];
  logic [W-1:0] in1_a [NREQ];
  logic [W-1:0] in2_a [NREQ];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ula_fl_arb #(.NREQ(NREQ), .EXP(EXP), .MAN(MAN), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_op  (req_op),
    .req_in1 (req_in1),
    .req_in2 (req_in2),
    .gnt     (gnt),
    .rsp_vld (rsp_vld),
    .rsp_id  (rsp_id),
    .rsp_out (rsp_out),
    .rsp_ack (rsp_ack),
    .alu_op  (alu_op),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out)
  );

  always_comb begin
    req_op  = '0;
    req_in1 = '0;
    req_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[4*i +: 4]  = op_a[i];
      req_in1[W*i +: W] = in1_a[i];
      req_in2[W*i +: W] = in2_a[i];
    end
  end

  // Stand-in for ula_fl: LOAD passes in1 through, other codes give distinct deterministic words.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      OP_LOAD: return a;
      OP_NEG:  return {~a[W-1], a[W-2:0]};
      OP_ABS:  return {1'b0, a[W-2:0]};
      default: return a ^ {b[W-2:0], 1'b0} ^ W'(op);
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_in1, alu_in2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_vld"}, 64'(rsp_vld), 64'd0);
    check({tag, "_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_out"}, 64'(rsp_out), 64'd0);
    check({tag, "_alu"}, {28'd0, alu_op, alu_in1 | alu_in2}, 64'd0);
  endtask

  // Leaves the bench at posedge+1 with rst low and the arbiter idle, ptr=0.
  task automatic do_reset();
    rst     = 1'b1;
    req     = '1;
    rsp_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = OP_LOAD; in1_a[i] = W'(32'h1000 + i); in2_a[i] = '0;
    end
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] exp_gnt;
    int              exp_id;
    logic [W-1:0]    base;
  } vec_t;

  // One full LOAD transaction; the winner carries base, losers carry ~base and keep requesting.
  task automatic do_txn(input vec_t v);
    req = v.rq;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = OP_LOAD;
      in1_a[i] = (i == v.exp_id) ? v.base : ~v.base;
      in2_a[i] = W'(i);
    end
    @(negedge clk);
    check("tbl_gnt", 64'(gnt), 64'(v.exp_gnt));
    @(posedge clk); #1;
    req = v.rq & ~v.exp_gnt;
    for (int i = 0; i < NREQ; i++) in1_a[i] = 32'hDEAD_0000;
    @(negedge clk);
    check("tbl_alu_op", 64'(alu_op), 64'(OP_LOAD));
    check("tbl_alu_in1", 64'(alu_in1), 64'(v.base));
    check("tbl_busy_gnt", 64'(gnt), 64'd0);
    check("tbl_early_vld", 64'(rsp_vld), 64'd0);
    repeat (LAT - 1) begin
      @(posedge clk);
      @(negedge clk);
      check("tbl_wait_vld", 64'(rsp_vld), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("tbl_vld", 64'(rsp_vld), 64'd1);
    check("tbl_id", 64'(rsp_id), 64'(v.exp_id));
    check("tbl_out", 64'(rsp_out), 64'(v.base));
    check("tbl_done_gnt", 64'(gnt), 64'd0);
    rsp_ack = 1'b1;
    @(posedge clk); #1;
    rsp_ack = 1'b0;
    req     = '0;
  endtask

  task automatic new_ops(input int i);
    op_a[i]  = 4'($urandom_range(0, 15));
    in1_a[i] = W'($urandom);
    in2_a[i] = W'($urandom);
  endtask

  initial begin
    vec_t tbl[11];
    int gidx[$];
    int gcyc[$];
    logic [IDW-1:0] hold_id;
    logic [W-1:0]   hold_out;
    logic           saw_vld;
    logic [NREQ-1:0] granted;
    logic            m_busy;
    int              m_rdy;
    int              m_ptr;
    int              m_id;
    logic [3:0]      m_op;
    logic [W-1:0]    m_in1;
    logic [W-1:0]    m_in2;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_vld;
    int              k;

    // Expected winners follow the pointer from 0 after reset.
    tbl[0]  = '{4'b1111, 4'b0001, 0, 32'h3F80_0000};
    tbl[1]  = '{4'b0001, 4'b0001, 0, 32'h4000_0000};
    tbl[2]  = '{4'b1001, 4'b1000, 3, 32'hC040_0000};
    tbl[3]  = '{4'b1010, 4'b0010, 1, 32'h4120_0000};
    tbl[4]  = '{4'b0100, 4'b0100, 2, 32'h00C0_0000};
    tbl[5]  = '{4'b0010, 4'b0010, 1, 32'h7F7F_FFFF};
    tbl[6]  = '{4'b0101, 4'b0100, 2, 32'h8000_0001};
    tbl[7]  = '{4'b1111, 4'b1000, 3, 32'h0000_0001};
    tbl[8]  = '{4'b0001, 4'b0001, 0, 32'h4049_0FDB};
    tbl[9]  = '{4'b1101, 4'b0100, 2, 32'hBF00_0000};
    tbl[10] = '{4'b0011, 4'b0001, 0, 32'h7F80_0000};

    do_reset();
    foreach (tbl[i]) do_txn(tbl[i]);

    // Fairness with everything requesting and ack tied high.
    do_reset();
    req     = '1;
    rsp_ack = 1'b1;
    for (int c = 0; c < 40 && gidx.size() < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        gidx.push_back($clog2(gnt));
        gcyc.push_back(c);
      end
    end
    check("fair_count", 64'(gidx.size()), 64'd5);
    for (int i = 0; i < gidx.size(); i++) begin
      check("fair_order", 64'(gidx[i]), 64'(i % NREQ));
      if (i > 0) check("fair_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(LAT + 2));
    end

    // Back-pressure: response held for 10 cycles while other requesters wait.
    do_reset();
    req      = 4'b0100;
    op_a[2]  = OP_NEG;
    in1_a[2] = 32'h3FC0_0000;
    @(negedge clk);
    check("bp_gnt", 64'(gnt), 64'b0100);
    @(posedge clk); #1;
    req = 4'b1001;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("bp_vld", 64'(rsp_vld), 64'd1);
    check("bp_out", 64'(rsp_out), 64'(32'hBFC0_0000));
    hold_id  = rsp_id;
    hold_out = rsp_out;
    check("bp_id", 64'(hold_id), 64'd2);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_stall_vld", 64'(rsp_vld), 64'd1);
      check("bp_stall_id", 64'(rsp_id), 64'(hold_id));
      check("bp_stall_out", 64'(rsp_out), 64'(hold_out));
      check("bp_stall_gnt", 64'(gnt), 64'd0);
    end
    rsp_ack = 1'b1;
    @(posedge clk); #1;
    rsp_ack = 1'b0;
    @(negedge clk);
    check("bp_ack_vld", 64'(rsp_vld), 64'd0);
    check("bp_next_gnt", 64'(gnt), 64'b1000);

    // Reset one cycle after a grant must drop the operation silently.
    do_reset();
    req      = 4'b0010;
    op_a[1]  = OP_ADD;
    in1_a[1] = 32'h4000_0000;
    in2_a[1] = 32'h4040_0000;
    @(negedge clk);
    check("rb_gnt", 64'(gnt), 64'b0010);
    @(posedge clk); #1;
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rb_after");
    saw_vld = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      saw_vld = saw_vld | rsp_vld;
    end
    check("rb_no_rsp", 64'(saw_vld), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic against a transaction-level model.
    do_reset();
    granted = '0;
    m_busy = 1'b0; m_rdy = 0; m_ptr = 0; m_id = 0;
    m_op = '0; m_in1 = '0; m_in2 = '0;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 399) == 0);
      rsp_ack = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && granted[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          new_ops(i);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          new_ops(i);
        end
      end
      @(negedge clk);
      exp_gnt = '0;
      k = -1;
      if (!m_busy && !rst) begin
        for (int off = 0; off < NREQ; off++) begin
          if (k < 0 && req[(m_ptr + off) % NREQ]) k = (m_ptr + off) % NREQ;
        end
        if (k >= 0) exp_gnt[k] = 1'b1;
      end
      exp_vld = m_busy && (c >= m_rdy);
      check("rnd_gnt", 64'(gnt), 64'(exp_gnt));
      check("rnd_vld", 64'(rsp_vld), 64'(exp_vld));
      if (exp_vld) begin
        check("rnd_id", 64'(rsp_id), 64'(m_id));
        check("rnd_out", 64'(rsp_out), 64'(alu_fn(m_op, m_in1, m_in2)));
      end
      check("rnd_alu_op", 64'(alu_op), 64'(m_op));
      check("rnd_alu_in", {alu_in1, alu_in2}, {m_in1, m_in2});
      granted = gnt;
      if (rst) begin
        m_busy = 1'b0; m_ptr = 0; m_id = 0;
        m_op = '0; m_in1 = '0; m_in2 = '0;
      end else if (k >= 0) begin
        m_busy = 1'b1;
        m_rdy  = c + LAT + 1;
        m_id   = k;
        m_op   = op_a[k];
        m_in1  = in1_a[k];
        m_in2  = in2_a[k];
        m_ptr  = (k + 1) % NREQ;
      end else if (exp_vld && rsp_ack) begin
        m_busy = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_fl_arb.md
# ula_fl_arb

Round-robin arbiter and sequencer that shares one combinational floating-point ALU (`ula_fl`, format `{sign, EXP-bit exponent, MAN-bit mantissa}`) among NREQ requesters. It grants one requester at a time and registers that requester's op and operands onto the ALU ports. It then holds them for LAT cycles so slow paths such as the divider can settle, and captures the result. The result is returned on a single valid/ack response channel tagged with the requester index. It sits between processor-side issuers (cores, accelerators) and a single `ula_fl` instance.

## Interface
Parameters:
- NREQ, 4: number of requesters, ≥2
- EXP, 8: exponent width
- MAN, 23: mantissa width; word width W = MAN+EXP+1
- LAT, 2: cycles the ALU inputs are held before the result is sampled, ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request, held until granted
- req_op  in  4·NREQ  opcode of requester i at [4i+3:4i]
- req_in1  in  W·NREQ  operand 1 of requester i at [W(i+1)-1:Wi]
- req_in2  in  W·NREQ  operand 2, same packing
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse
- rsp_vld  out  1  result valid
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result
- rsp_out  out  W  result word
- rsp_ack  in  1  response consumed
- alu_op  out  4  to `ula_fl` op
- alu_in1, alu_in2  out  W  to `ula_fl` operands
- alu_out  in  W  from `ula_fl` out

## Operation
- FSM states:
  - IDLE: if any req is set, pick the winner (below), pulse gnt[k], latch req_op/in1/in2 of k into alu_op/alu_in1/alu_in2, latch k into id_r and into rsp_id, set cnt=LAT-1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: alu_* are stable. If cnt==0, rsp_out<=alu_out, rsp_vld<=1, go to DONE; else cnt--.
  - DONE: rsp_vld=1, rsp_out and rsp_id held. On rsp_ack, rsp_vld<=0 and go to IDLE. No grant is issued in the ack cycle.
- Round-robin: pointer ptr resets to 0. The winner is the first set req at index ptr, ptr+1, … modulo NREQ. After granting k, ptr<=(k+1) mod NREQ.
- The requester samples gnt on the same edge it is issued and may drop req or change its operands in the next cycle. The operands are already latched.
- Opcodes are forwarded unmodified (0 NOP, 1 LOAD, 2 ADD, 3 MLT, 4 DIV, 5 NEG, 6–11 compare/logic, 12 ABS, 13 SIGN). Unused codes are passed through, and their result is whatever `ula_fl` produces.
- alu_* keep their last value in IDLE and DONE. They do not return to 0.
- rst at any point, including BUSY or DONE, drops the in-flight operation silently, with no response. State goes to IDLE, ptr=0, and every output returns to its reset value.

## Timing
- Reset values: gnt=0, rsp_vld=0, rsp_id=0, rsp_out=0, alu_op=0, alu_in1=0, alu_in2=0, state IDLE, ptr=0, cnt=0.
- Grant at edge T means alu_* are valid from T. rsp_vld rises at edge T+LAT, and rsp_out equals alu_out sampled at that edge.
- With rsp_ack tied high, the minimum spacing between grants is LAT+2 cycles.
- gnt is never asserted when state≠IDLE, and never for an index whose req=0.
- Simultaneous requests are resolved only by ptr. Requests are never reordered against the grant order.

## Structure
- Package `ula_fl_arb_pkg`:
  - state enum (IDLE, BUSY, DONE)
  - opcode constants OP_NOP…OP_SIGN (0–13)
  - function for the word width W
- Sub-module `rr_pick #(N)`: req, ptr → one-hot grant and binary index plus a `found` flag. It is purely combinational.
- The FSM, counter, and registers live in `ula_fl_arb`. `ula_fl` is instantiated outside this block.

## Test plan
- Reset: assert rst for 3 cycles with req=4'b1111. Required: gnt=0, rsp_vld=0, all alu_* =0, and the first grant after release goes to requester 0.
- Single LOAD: requester 2 sends op=1, in1=32'h00C00000, LAT=2, using a real `ula_fl` with default parameters. Required: gnt[2] at T, rsp_vld at T+2, rsp_out=32'h00C00000, rsp_id=2.
- Fairness: all four req held high, rsp_ack=1. Required: grant order 0,1,2,3,0, with exactly LAT+2 cycles between grants.
- Back-pressure: rsp_ack held low for 10 cycles after rsp_vld. Required: rsp_out and rsp_id stable, no gnt during the stall, and the next gnt exactly 1 cycle after the ack edge.
- Pointer skip: ptr=3 with only req[1] set. Required: gnt[1], then ptr=2, and a later req[0]|req[2] grants 2 first.
- Reset mid-BUSY: assert rst 1 cycle after a grant. Required: no rsp_vld ever for that operation, and the outputs match the reset values the next cycle.
